// File: rtl/timer_counter.sv
// Memory-mapped timer/counter: CTRL/PRESET/COUNT registers, down-counting FSM, interrupt request.
// Latency: register writes land on the next edge; Dout is combinational (zero read latency).
// Backpressure: none; a write cycle stalls the FSM and irq_flag for that cycle only.
//
// Ports:
//   clk   - system clock, rising-edge
//   reset - synchronous active-high reset
//   Addr  - word address [31:2]; only Addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//   WE    - full-word write enable, pre-qualified for this instance
//   Din   - write data
//   Dout  - read data mux
//   IRQ   - CTRL[3] (IM) & irq_flag
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state_q,    state_d;
    logic [3:0]  ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic        irq_flag_q, irq_flag_d;

    // Upper address bits belong to the bridge's range decode, not to us.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Addr[31:4];

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (WE) begin
            // A write cycle does the write and nothing else; the FSM resumes next cycle.
            case (Addr[3:2])
                A_CTRL:   ctrl_d   = Din[3:0];
                A_PRESET: preset_d = Din;
                default:  ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[0]) begin
                        irq_flag_d = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_d = S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // Covers PRESET of 0 or 1 too: never decrement below zero.
                        count_d    = 32'd0;
                        irq_flag_d = 1'b1;
                        state_d    = S_INT;
                    end
                end
                S_INT: begin
                    if (ctrl_q[2:1] == 2'b00) begin
                        // One-shot: drop enable, keep the flag until software rewrites CTRL.
                        ctrl_d[0] = 1'b0;
                    end else begin
                        // Periodic: single-cycle pulse, enable stays set so IDLE reloads.
                        irq_flag_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            A_CTRL:   Dout = {28'd0, ctrl_q};
            A_PRESET: Dout = preset_q;
            A_COUNT:  Dout = count_q;
            default:  Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule
